// File: rtl/line_memory_pkg.sv
// ============================================================================
// Module : line_memory_pkg
// Brief  : Shared widths and FSM state encoding for line_memory.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package line_memory_pkg;

    localparam int LINE_W   = 256;
    localparam int ADDR_W   = 32;
    localparam int OFFSET_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/line_memory_array.sv
// ============================================================================
// Module : line_memory_array
// Brief  : DEPTH x LINE_W single-port storage, synchronous write, async read.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_memory_array
    import line_memory_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [LINE_W-1:0] i_wdata,
    output logic [LINE_W-1:0] o_rdata
);

    // Contents deliberately survive reset.
    logic [LINE_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

`default_nettype wire

// File: rtl/line_memory.sv
// ============================================================================
// Module : line_memory
// Brief  : Fixed-latency 256-bit line memory with request/ack handshake.
//          Define LINE_MEMORY_PROTOCOL_CHECK_EN to build the sticky err_o checker.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_memory
    import line_memory_pkg::*;
#(
    parameter int DEPTH   = 512,
    parameter int LATENCY = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              write_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LINE_W-1:0] data_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o,
    output logic              err_o
);

    localparam int          c_IDX_W  = $clog2(DEPTH);
    localparam logic [7:0]  c_LAT_M1 = 8'(LATENCY - 1);

    state_t              r_state;
    logic [7:0]          r_cnt;
    logic                r_write;
    logic [c_IDX_W-1:0]  r_idx;
    logic [LINE_W-1:0]   r_wdata;
    logic                r_ack;
    logic [LINE_W-1:0]   r_data;

    logic [c_IDX_W-1:0]  w_idx;
    logic [c_IDX_W-1:0]  w_mem_idx;
    logic [LINE_W-1:0]   w_rdata;
    logic                w_we;
    logic                w_unused;

    assign w_idx    = addr_i[OFFSET_W +: c_IDX_W];
    assign w_unused = ^{addr_i[ADDR_W-1:OFFSET_W+c_IDX_W], addr_i[OFFSET_W-1:0]};

    // Single port: the incoming index is only needed when LATENCY=1 loads data_o
    // straight out of IDLE; otherwise the captured index drives the array.
    assign w_mem_idx = (r_state == IDLE) ? w_idx : r_idx;
    assign w_we      = (r_state == DONE) && r_write;

    line_memory_array #(
        .DEPTH (DEPTH),
        .IDX_W (c_IDX_W)
    ) u_array (
        .clk_i   (clk_i),
        .i_we    (w_we),
        .i_idx   (w_mem_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
            r_write <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_ack   <= 1'b0;
            r_data  <= '0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (enable_i) begin
                        r_write <= write_i;
                        r_idx   <= w_idx;
                        r_wdata <= data_i;
                        r_cnt   <= c_LAT_M1;
                        if (LATENCY == 1) begin
                            r_state <= DONE;
                            r_ack   <= 1'b1;
                            if (!write_i) begin
                                r_data <= w_rdata;
                            end
                        end else begin
                            r_state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    r_cnt <= r_cnt - 8'd1;
                    if (r_cnt == 8'd1) begin
                        r_state <= DONE;
                        r_ack   <= 1'b1;
                        if (!r_write) begin
                            r_data <= w_rdata;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ack_o  = r_ack;
    assign data_o = r_data;

`ifdef LINE_MEMORY_PROTOCOL_CHECK_EN
    logic [ADDR_W-1:OFFSET_W] r_addr_hi;
    logic                     r_err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_addr_hi <= '0;
            r_err     <= 1'b0;
        end else begin
            if (r_state == IDLE && enable_i) begin
                r_addr_hi <= addr_i[ADDR_W-1:OFFSET_W];
            end
            if (r_state == BUSY && (!enable_i || write_i != r_write ||
                                    addr_i[ADDR_W-1:OFFSET_W] != r_addr_hi)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_line_memory.sv
// ============================================================================
// Module : tb_line_memory
// Brief  : Directed self-checking bench for line_memory (LATENCY=10 and =1).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_line_memory;
    import line_memory_pkg::*;

`ifdef LINE_MEMORY_PROTOCOL_CHECK_EN
    localparam logic c_EXP_ERR = 1'b1;
`else
    localparam logic c_EXP_ERR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              en1;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
    logic              ack;
    logic              err;
    logic [LINE_W-1:0] rdata;
    logic              ack1;
    logic              err1;
    logic [LINE_W-1:0] rdata1;

    logic [LINE_W-1:0] p1   = {8{32'h1111_0001}};
    logic [LINE_W-1:0] p2   = {8{32'h0202_C0DE}};
    logic [LINE_W-1:0] pa5  = {32{8'hA5}};
    logic [LINE_W-1:0] p16  = {8{32'h1616_0010}};
    logic [LINE_W-1:0] pbad = {8{32'hDEAD_BEEF}};
    logic [LINE_W-1:0] p4   = {8{32'h4444_0080}};
    logic [LINE_W-1:0] p5   = {8{32'h5555_00A0}};

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    line_memory #(.DEPTH(512), .LATENCY(10)) u_dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .enable_i (en),
        .write_i  (wr),
        .addr_i   (addr),
        .data_i   (wdata),
        .ack_o    (ack),
        .data_o   (rdata),
        .err_o    (err)
    );

    line_memory #(.DEPTH(512), .LATENCY(1)) u_dut_l1 (
        .clk_i    (clk),
        .rst_i    (rst),
        .enable_i (en1),
        .write_i  (wr),
        .addr_i   (addr),
        .data_i   (wdata),
        .ack_o    (ack1),
        .data_o   (rdata1),
        .err_o    (err1)
    );

    task automatic check(input string tag, input logic [LINE_W-1:0] got,
                         input logic [LINE_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issues one request at a negedge and returns the cycle count to ack (-1 on timeout).
    task automatic run_req(input logic w, input logic [ADDR_W-1:0] a,
                           input logic [LINE_W-1:0] d, output int lat);
        lat = -1;
        @(negedge clk);
        en = 1'b1; wr = w; addr = a; wdata = d;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (ack) begin
                lat = k;
                break;
            end
        end
        en = 1'b0;
    endtask

    initial begin
        int lat;
        int ack_a;
        int ack_b;
        logic [2:0] l1_acks;

        rst = 1'b1; en = 1'b0; en1 = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_ack", 256'(ack), 256'(0));
        check("rst_data", rdata, '0);
        check("rst_err", 256'(err), 256'(0));
        check("rst_ack_l1", 256'(ack1), 256'(0));
        rst = 1'b0;

        // Seed line 2, then reset: contents must survive.
        run_req(1'b1, 32'h0000_0040, p2, lat);
        check("wr_line2_lat", 256'(lat), 256'(10));
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;

        run_req(1'b0, 32'h0000_0040, '0, lat);
        check("rd_0x40_lat", 256'(lat), 256'(10));
        check("rd_0x40_data", rdata, p2);
        @(negedge clk);
        check("rd_0x40_ack_one_cycle", 256'(ack), 256'(0));

        run_req(1'b1, 32'h0000_0100, pa5, lat);
        check("wr_0x100_lat", 256'(lat), 256'(10));
        check("wr_keeps_data_o", rdata, p2);
        run_req(1'b0, 32'h0000_0100, '0, lat);
        check("rd_0x100_data", rdata, pa5);
        run_req(1'b0, 32'h0000_4100, '0, lat);
        check("rd_alias_0x4100", rdata, pa5);

        // Back-to-back with enable held: acks at 10 and 21.
        run_req(1'b1, 32'h0000_0020, p1, lat);
        ack_a = -1; ack_b = -1;
        @(negedge clk);
        en = 1'b1; wr = 1'b0; addr = 32'h0000_0020;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (ack && ack_a < 0) begin
                ack_a = k;
                check("b2b_first_data", rdata, p1);
                addr = 32'h0000_0040;
            end else if (ack) begin
                ack_b = k;
                check("b2b_second_data", rdata, p2);
                break;
            end
        end
        en = 1'b0;
        check("b2b_first_ack", 256'(ack_a), 256'(10));
        check("b2b_second_ack", 256'(ack_b), 256'(21));

        // Reset in the middle of a write must leave line 0x10 untouched.
        run_req(1'b1, 32'h0000_0200, p16, lat);
        run_req(1'b0, 32'h0000_0200, '0, lat);
        check("rd_0x200_before", rdata, p16);
        @(negedge clk);
        en = 1'b1; wr = 1'b1; addr = 32'h0000_0200; wdata = pbad;
        ack_a = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (ack) ack_a++;
        end
        rst = 1'b1; en = 1'b0;
        #1;
        check("midrst_no_ack_seen", 256'(ack_a), 256'(0));
        check("midrst_ack", 256'(ack), 256'(0));
        check("midrst_data", rdata, '0);
        @(negedge clk); rst = 1'b0;
        run_req(1'b0, 32'h0000_0200, '0, lat);
        check("rd_0x200_after_rst", rdata, p16);

        // Address changed mid-BUSY: original transaction wins.
        run_req(1'b1, 32'h0000_0080, p4, lat);
        run_req(1'b1, 32'h0000_00A0, p5, lat);
        check("err_before_viol", 256'(err), 256'(0));
        @(negedge clk);
        en = 1'b1; wr = 1'b0; addr = 32'h0000_0080;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 3) addr = 32'h0000_00A0;
            if (k == 4) check("err_after_viol", 256'(err), 256'(c_EXP_ERR));
            if (ack) begin
                lat = k;
                break;
            end
        end
        en = 1'b0;
        check("viol_lat", 256'(lat), 256'(10));
        check("viol_data", rdata, p4);
        repeat (3) @(negedge clk);
        check("err_sticky", 256'(err), 256'(c_EXP_ERR));
        rst = 1'b1;
        @(negedge clk);
        check("err_cleared", 256'(err), 256'(0));
        rst = 1'b0;

        // LATENCY=1: ack at 1, gap at 2, re-accept at 2 -> ack at 3.
        @(negedge clk);
        en1 = 1'b1; wr = 1'b0; addr = 32'h0000_0000;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            l1_acks[k-1] = ack1;
        end
        en1 = 1'b0;
        check("l1_ack_c1", 256'(l1_acks[0]), 256'(1));
        check("l1_ack_c2", 256'(l1_acks[1]), 256'(0));
        check("l1_ack_c3", 256'(l1_acks[2]), 256'(1));
        check("main_err_idle", 256'(err), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/line_memory.md
LINE_MEMORY -- requirements
Module: line_memory

Interface
REQ-001 SHALL have parameter DEPTH, default 512, number of 256-bit lines stored (power of two).
REQ-002 SHALL have parameter LATENCY, default 10, cycles from request acceptance to ack (legal range 1..255).
REQ-003 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port enable_i  input  1  request valid from the initiator; held high until ack.
REQ-006 SHALL have port write_i  input  1  1 = line write, 0 = line read.
REQ-007 SHALL have port addr_i  input  32  byte address; bits [4:0] ignored.
REQ-008 SHALL have port data_i  input  256  write line data.
REQ-009 SHALL have port ack_o  output  1  one-cycle completion pulse.
REQ-010 SHALL have port data_o  output  256  read line data.
REQ-011 SHALL have port err_o  output  1  sticky protocol-violation flag.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-013 In IDLE with enable_i=1, SHALL capture write_i, line index and data_i at cycle T, load the latency counter with LATENCY-1, and go to BUSY (LATENCY>1) or DONE (LATENCY=1).
REQ-014 In BUSY, SHALL decrement the counter each cycle and go to DONE when the counter reaches 0.
REQ-015 ack_o SHALL be high exactly in the DONE cycle, i.e. cycle T+LATENCY, for one cycle.
REQ-016 Reads SHALL drive the captured line onto data_o in the DONE cycle; data_o SHALL hold that value until the next read completes.
REQ-017 Writes SHALL commit the captured data_i to the array at the end of the DONE cycle; data_o SHALL be unchanged by writes.
REQ-018 Line index SHALL be addr_i[5+log2(DEPTH)-1:5]; upper address bits SHALL be ignored (aliasing wrap-around).
REQ-019 DONE SHALL always return to IDLE; enable_i SHALL be ignored in DONE, so back-to-back requests have one idle gap minimum (next acceptance earliest at T+LATENCY+1).
REQ-020 Inputs sampled at acceptance SHALL be used; changes to addr_i/data_i/write_i during BUSY SHALL NOT affect the transaction.
REQ-021 A read of a line written by an earlier completed write SHALL return the written data (no read-during-commit hazard, since requests are serialized).

Reset
REQ-022 On rst_i=1 (any cycle, including mid-BUSY): state=IDLE, counter=0, ack_o=0, data_o=0, err_o=0.
REQ-023 A write interrupted by reset before its DONE edge SHALL NOT modify the array.
REQ-024 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-025 Macro LINE_MEMORY_PROTOCOL_CHECK_EN defined: err_o SHALL set (sticky until reset) if, in BUSY, enable_i drops or addr_i[31:5]/write_i differ from captured values.
REQ-026 Macro undefined: checker logic absent, err_o tied to 0.

Structure
REQ-027 Package line_memory_pkg SHALL hold LINE_W=256, ADDR_W=32, OFFSET_W=5 and the state enum.
REQ-028 Storage SHALL be a sub-module line_memory_array (DEPTH x 256, single port, synchronous write, combinational read); FSM and counter stay in line_memory.

Verification
REQ-029 Reset then read addr 0x0000_0040 (LATENCY=10, accepted at cycle 0) -> ack_o high at cycle 10 only, data_o = array preload of line 2.
REQ-030 Write 0xA5 repeated to 0x0000_0100, then read 0x0000_0100 -> second ack, data_o = 0xA5 pattern; read 0x0000_4100 (DEPTH=512) -> same data (alias).
REQ-031 enable_i held high continuously for reads of 0x20 then 0x40 -> acks at cycles 10 and 21, data_o updates at each ack.
REQ-032 Assert rst_i at cycle 5 of a write to 0x0000_0200 -> no ack, line 0x10 unchanged on later read, ack_o/data_o=0 after reset.
REQ-033 LINE_MEMORY_PROTOCOL_CHECK_EN defined, change addr_i from 0x80 to 0xA0 at cycle 3 of BUSY -> err_o=1 from next cycle until rst_i; undefined -> err_o stays 0, transaction completes at 0x80.
REQ-034 LATENCY=1, read 0x0 accepted at cycle 0 -> ack_o at cycle 1, next acceptance no earlier than cycle 2.
